// File: rtl/clk_switch_ctrl.sv
// Clock-select switch sequencer: quiesces downstream logic, flips the registered
// select for a glitch-free clock mux, waits for the select to settle, then releases.
module clk_switch_ctrl #(
  parameter int unsigned SETTLE_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter bit          RESET_SEL      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  output logic sel,
  output logic quiesce_req,
  input  logic quiesce_ack,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned SW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LOAD  = SW'(SETTLE_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUIESCE = 2'd1,
    SETTLE  = 2'd2,
    RELEASE = 2'd3
  } state_e;

  state_e        state_q;
  logic          sel_q;
  logic          target_q;
  logic          quiesce_req_q;
  logic          done_q;
  logic          err_q;
  logic [TW-1:0] tcnt_q;
  logic [SW-1:0] scnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      sel_q         <= RESET_SEL;
      target_q      <= RESET_SEL;
      quiesce_req_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      tcnt_q        <= '0;
      scnt_q        <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // Acceptance uses the same decode as req_ready so the two never disagree.
          if (req_valid && !done_q && !err_q) begin
            if (req_sel == sel_q) begin
              done_q <= 1'b1;
            end else begin
              target_q      <= req_sel;
              tcnt_q        <= '0;
              quiesce_req_q <= 1'b1;
              state_q       <= QUIESCE;
            end
          end
        end
        QUIESCE: begin
          // Ack takes priority over a timeout expiring on the same edge.
          if (quiesce_ack) begin
            sel_q   <= target_q;
            scnt_q  <= SETTLE_LOAD;
            state_q <= SETTLE;
          end else if (tcnt_q == TIMEOUT_LAST) begin
            quiesce_req_q <= 1'b0;
            err_q         <= 1'b1;
            tcnt_q        <= '0;
            state_q       <= IDLE;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
        SETTLE: begin
          if (scnt_q == SETTLE_LAST) begin
            scnt_q        <= '0;
            quiesce_req_q <= 1'b0;
            state_q       <= RELEASE;
          end else begin
            scnt_q <= scnt_q - SW'(1);
          end
        end
        RELEASE: begin
          if (!quiesce_ack) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = (state_q == IDLE) && !done_q && !err_q;
  assign busy        = (state_q != IDLE);
  assign sel         = sel_q;
  assign quiesce_req = quiesce_req_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed bench for clk_switch_ctrl with SETTLE_CYCLES=4, TIMEOUT_CYCLES=16, RESET_SEL=0.
module tb_clk_switch_ctrl;

  logic clk = 1'b0;
  logic rst, req_valid, req_sel, quiesce_ack;
  logic req_ready, sel, quiesce_req, busy, done, err;

  int checks   = 0;
  int failures = 0;
  int dcount;

  clk_switch_ctrl #(
    .SETTLE_CYCLES (4),
    .TIMEOUT_CYCLES(16),
    .RESET_SEL     (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_sel    (req_sel),
    .req_ready  (req_ready),
    .sel        (sel),
    .quiesce_req(quiesce_req),
    .quiesce_ack(quiesce_ack),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Advance one edge and land 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_sel = 1'b0; quiesce_ack = 1'b0;
    step(); step();
    chk("rst_sel", sel, 1'b0);
    chk("rst_qreq", quiesce_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    rst = 1'b0;
    step();
    chk("post_rst_ready", req_ready, 1'b1);

    // Same-select request completes without quiescing.
    req_valid = 1'b1; req_sel = 1'b0;
    step();
    req_valid = 1'b0;
    chk("same_done", done, 1'b1);
    chk("same_busy", busy, 1'b0);
    chk("same_qreq", quiesce_req, 1'b0);
    chk("same_sel", sel, 1'b0);
    chk("same_ready_low", req_ready, 1'b0);
    step();
    chk("same_done_clr", done, 1'b0);
    chk("same_ready", req_ready, 1'b1);

    // Full switch to 1, ack 3 cycles after quiesce_req rises.
    req_valid = 1'b1; req_sel = 1'b1;
    step();
    req_valid = 1'b0;
    chk("sw_qreq_rise", quiesce_req, 1'b1);
    chk("sw_busy", busy, 1'b1);
    chk("sw_sel_old", sel, 1'b0);
    step();
    step();
    chk("sw_sel_wait", sel, 1'b0);
    quiesce_ack = 1'b1;
    step();
    chk("sw_sel_flip", sel, 1'b1);
    chk("sw_qreq_hold0", quiesce_req, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sw_qreq_settle", quiesce_req, 1'b1);
    end
    step();
    chk("sw_qreq_fall", quiesce_req, 1'b0);
    chk("sw_busy_rel", busy, 1'b1);
    step();
    chk("sw_rel_nodone", done, 1'b0);
    chk("sw_rel_busy", busy, 1'b1);
    quiesce_ack = 1'b0;
    step();
    chk("sw_done", done, 1'b1);
    chk("sw_busy_fall", busy, 1'b0);
    chk("sw_sel_final", sel, 1'b1);
    chk("sw_noerr", err, 1'b0);
    step();
    chk("sw_done_clr", done, 1'b0);
    chk("sw_ready", req_ready, 1'b1);

    // Timeout: no ack for 16 QUIESCE cycles.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("to_rst_sel", sel, 1'b0);
    req_valid = 1'b1; req_sel = 1'b1;
    step();
    req_valid = 1'b0;
    for (int i = 1; i < 16; i++) begin
      chk("to_qreq_high", quiesce_req, 1'b1);
      chk("to_err_low", err, 1'b0);
      step();
    end
    chk("to_qreq_16th", quiesce_req, 1'b1);
    step();
    chk("to_err", err, 1'b1);
    chk("to_qreq_low", quiesce_req, 1'b0);
    chk("to_sel", sel, 1'b0);
    chk("to_busy", busy, 1'b0);
    chk("to_nodone", done, 1'b0);
    step();
    chk("to_err_clr", err, 1'b0);
    chk("to_ready", req_ready, 1'b1);

    // Ack on the 16th QUIESCE cycle wins over the timeout.
    req_valid = 1'b1; req_sel = 1'b1;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 15; i++) step();
    quiesce_ack = 1'b1;
    step();
    chk("late_sel", sel, 1'b1);
    chk("late_noerr", err, 1'b0);
    chk("late_busy", busy, 1'b1);
    for (int i = 0; i < 4; i++) step();
    chk("late_qreq_fall", quiesce_req, 1'b0);
    quiesce_ack = 1'b0;
    step();
    chk("late_done", done, 1'b1);
    chk("late_noerr2", err, 1'b0);
    step();

    // Reset during SETTLE aborts silently.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = 1'b1; req_sel = 1'b1;
    step();
    req_valid = 1'b0;
    quiesce_ack = 1'b1;
    step();
    chk("abort_sel_set", sel, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; quiesce_ack = 1'b0;
    chk("abort_sel", sel, 1'b0);
    chk("abort_qreq", quiesce_req, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_err", err, 1'b0);
    dcount = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done || err) dcount++;
    end
    chk_int("abort_no_pulse", dcount, 0);
    chk("abort_ready", req_ready, 1'b1);

    // Requests while busy are ignored.
    req_valid = 1'b1; req_sel = 1'b1;
    step();
    req_sel = 1'b0;
    dcount = 0;
    req_valid = ~req_valid;
    step();
    if (done) dcount++;
    quiesce_ack = 1'b1;
    req_valid = ~req_valid;
    step();
    if (done) dcount++;
    for (int i = 0; i < 4; i++) begin
      req_valid = ~req_valid;
      step();
      if (done) dcount++;
    end
    quiesce_ack = 1'b0;
    req_valid = ~req_valid;
    step();
    if (done) dcount++;
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) dcount++;
    end
    chk_int("busy_ign_done_count", dcount, 1);
    chk("busy_ign_sel", sel, 1'b1);
    chk("busy_ign_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_switch_ctrl.md
CLK_SWITCH_CTRL -- requirements
Module: clk_switch_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 8: reference-clock cycles during which sel is held stable before quiesce is released; legal range 1..255.
REQ-002 Parameter TIMEOUT_CYCLES, default 64: maximum reference-clock cycles spent waiting for quiesce_ack to assert; legal range 1..65535.
REQ-003 Parameter RESET_SEL, default 0: value of sel after reset.
REQ-004 clk  input  1  reference clock; this is the block's only clock and all logic is on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 req_valid  input  1  switch request is valid.
REQ-007 req_sel  input  1  requested clock select (0 = clk_0, 1 = clk_1).
REQ-008 req_ready  output  1  block accepts a request; a request is accepted on any edge where req_valid & req_ready.
REQ-009 sel  output  1  registered select driving the downstream glitch-free clock mux.
REQ-010 quiesce_req  output  1  asks downstream logic to stop using the muxed clock.
REQ-011 quiesce_ack  input  1  downstream has quiesced; synchronous to clk.
REQ-012 busy  output  1  high whenever state != IDLE.
REQ-013 done  output  1  one-cycle pulse indicating the request completed successfully.
REQ-014 err  output  1  one-cycle pulse indicating the request was aborted on timeout.

Function
REQ-015 FSM states: IDLE, QUIESCE, SETTLE, RELEASE; all outputs are driven from registers or decoded from state only, with no input-to-output combinational path.
REQ-016 req_ready shall be 1 only in IDLE with done and err low.
REQ-017 IDLE, accept with req_sel == sel: state stays IDLE, quiesce_req stays 0, and done pulses on the next cycle.
REQ-018 IDLE, accept with req_sel != sel: latch the target, clear the timeout counter, enter QUIESCE; quiesce_req = 1 from the next cycle onward.
REQ-019 QUIESCE: the timeout counter increments each cycle; on an edge sampling quiesce_ack = 1, sel <= target, the settle counter is loaded with SETTLE_CYCLES, and the FSM enters SETTLE.
REQ-020 QUIESCE: if TIMEOUT_CYCLES cycles elapse without ack: quiesce_req <= 0, err pulses once, sel is unchanged, and the FSM returns to IDLE.
REQ-021 If ack and the timeout expiry occur on the same edge, ack wins and the switch proceeds.
REQ-022 SETTLE: the counter decrements each cycle; sel and quiesce_req are held; after exactly SETTLE_CYCLES cycles in SETTLE, quiesce_req <= 0 and the FSM enters RELEASE.
REQ-023 RELEASE: on an edge sampling quiesce_ack = 0, done pulses the next cycle and the FSM enters IDLE; there is no timeout in RELEASE.
REQ-024 req_valid and req_sel are ignored while busy; requests are not queued.
REQ-025 sel changes only on the QUIESCE-to-SETTLE edge, at most once per accepted request.
REQ-026 done and err are never high together, and each is high for exactly one cycle per request.
REQ-027 Counters shall be sized internally from the parameters and shall not wrap within their legal ranges.

Reset
REQ-028 rst high at an edge forces: state IDLE, sel = RESET_SEL, quiesce_req = 0, busy = 0, done = 0, err = 0, counters = 0, latched target = RESET_SEL.
REQ-029 Reset mid-switch (any state) takes effect on the same edge with the REQ-028 values; no done or err is emitted for the aborted request.
REQ-030 req_ready = 1 on the first cycle after rst deasserts.

Verification (SETTLE_CYCLES=4, TIMEOUT_CYCLES=16, RESET_SEL=0)
REQ-031 Reset, then req_sel=0 -> no quiesce_req, sel stays 0, done pulses 1 cycle after accept.
REQ-032 req_sel=1 with ack returned 3 cycles after quiesce_req rises and dropped 2 cycles after quiesce_req falls -> sel=1 on the ack edge, quiesce_req falls 4 cycles later, done pulses once, busy falls with done.
REQ-033 req_sel=1 with ack never asserted -> quiesce_req high for 16 cycles, then err pulses, sel stays 0, req_ready=1 on the next cycle.
REQ-034 Ack arriving on the 16th QUIESCE cycle -> the switch completes with done and no err.
REQ-035 rst asserted during SETTLE -> next cycle sel=0, quiesce_req=0, busy=0, and no done or err pulse.
REQ-036 req_valid toggling with req_sel=0 while a switch to 1 is busy -> ignored; final sel=1 and exactly one done pulse.
